// File: rtl/sap_boot_loader.sv
// Program loader / run sequencer for the SAP core: streams an image into RAM, pulses CPU reset,
// then supervises the run with an HLT watchdog. Define SAP_BOOT_ZERO_FILL_EN to zero the unused RAM tail.
module sap_boot_loader #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int RST_CYCLES  = 2,
    parameter int RUN_TIMEOUT = 256,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              prog_mode,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_reset,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              truncated,
    output logic [CNT_W-1:0]  run_cycles
);
    localparam int AW1  = ADDR_W + 1;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [AW1-1:0]   LAST_A   = AW1'(DEPTH - 1);
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT - 1);
`ifdef SAP_BOOT_ZERO_FILL_EN
    localparam logic [AW1-1:0]   END_A    = AW1'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_RST, S_RUN, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_RUN, S_DONE, S_ERR} state_t;
`endif

    state_t            state_q;
    logic [AW1-1:0]    addr_q;      // one bit wider than the RAM address so DEPTH is representable
    logic [RC_W-1:0]   rst_cnt_q;
    logic              in_ready_q;
    logic              prog_mode_q;
    logic              prog_we_q;
    logic [ADDR_W-1:0] prog_addr_q;
    logic [DATA_W-1:0] prog_data_q;
    logic              cpu_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;
    logic              truncated_q;
    logic [CNT_W-1:0]  run_cycles_q;
    logic [CNT_W-1:0]  run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rst_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            prog_mode_q  <= 1'b0;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= '0;
            prog_data_q  <= '0;
            cpu_reset_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            truncated_q  <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q      <= S_LOAD;
                        addr_q       <= '0;
                        in_ready_q   <= 1'b1;
                        prog_mode_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        truncated_q  <= 1'b0;
                        run_cycles_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_ready_q) begin
                        prog_we_q <= 1'b0;
                        if (in_valid) begin
                            prog_we_q   <= 1'b1;
                            prog_addr_q <= addr_q[ADDR_W-1:0];
                            prog_data_q <= in_data;
                            addr_q      <= addr_q + AW1'(1);
                            if (in_last || addr_q == LAST_A) begin
                                in_ready_q  <= 1'b0;
                                truncated_q <= ~in_last;
                            end
                        end
                    end else begin
                        // Drain cycle: the final word's write is on the bus, so reset/fill starts after it.
                        prog_we_q <= 1'b0;
                        rst_cnt_q <= '0;
`ifdef SAP_BOOT_ZERO_FILL_EN
                        if (addr_q != END_A) begin
                            state_q <= S_FILL;
                        end else begin
                            state_q     <= S_RST;
                            cpu_reset_q <= 1'b1;
                        end
`else
                        state_q     <= S_RST;
                        cpu_reset_q <= 1'b1;
`endif
                    end
                end
`ifdef SAP_BOOT_ZERO_FILL_EN
                S_FILL: begin
                    if (addr_q == END_A) begin
                        prog_we_q   <= 1'b0;
                        state_q     <= S_RST;
                        cpu_reset_q <= 1'b1;
                    end else begin
                        prog_we_q   <= 1'b1;
                        prog_addr_q <= addr_q[ADDR_W-1:0];
                        prog_data_q <= '0;
                        addr_q      <= addr_q + AW1'(1);
                    end
                end
`endif
                S_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q     <= S_RUN;
                        cpu_reset_q <= 1'b0;
                        prog_mode_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RC_W'(1);
                    end
                end
                S_RUN: begin
                    run_cycles_q <= run_cycles_d;
                    // A halt seen on the watchdog cycle still counts as a clean finish.
                    if (cpu_halted) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (run_cycles_d == RUN_LAST) begin
                        state_q     <= S_ERR;
                        timeout_q   <= 1'b1;
                        prog_mode_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign prog_mode  = prog_mode_q;
    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign truncated  = truncated_q;
    assign run_cycles = run_cycles_q;

endmodule
